uart_receive: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_receive.sv | 162 ++++++++++++++++
 tb/tb_uart_receive.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_receive / uart_send pair: FSM state encoding,
// default baud divider and payload width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input. Reset sets both
// stages to 1 so an idle-high serial line never shows a false edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Optional macro UART_RX_PARITY_EN switches to 8E1 and adds a parity_error pulse.
import uart_pkg::*;

module uart_receive #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_byte,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 ready
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] byte_n;
    logic                 valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                 par, par_n;
    logic                 perr_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data_byte   <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par          <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            data_byte   <= byte_n;
            data_valid  <= valid_n;
            frame_error <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par          <= par_n;
            parity_error <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        byte_n  = data_byte;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Re-check at mid start bit; a high line here was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a start bit right behind it is caught.
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        byte_n  = shreg;
                        valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_n  = ^{shreg, par};
`endif
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at CLKS_PER_BIT = 16; the bench itself plays
// the transmitter, driving rx on the falling clock edge.
module tb_uart_receive;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_byte;
    logic       data_valid, frame_error, ready;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int nchk = 0;
    int nerr = 0;

    int         cyc  = 0;
    int         vcnt = 0, fcnt = 0, pcnt = 0;
    int         vcyc = 0, fall_cyc = 0;
    logic [7:0] vlast = 8'h00;
    logic [7:0] vals [$];
    bit         both_seen = 1'b0;

    uart_receive #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_byte   (data_byte),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .ready       (ready)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            vcnt  <= vcnt + 1;
            vlast <= data_byte;
            vcyc  <= cyc;
            vals.push_back(data_byte);
        end
        if (frame_error) fcnt <= fcnt + 1;
        if (data_valid && frame_error) both_seen <= 1'b1;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pcnt <= pcnt + 1;
`endif
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Full frame: start, 8 data bits LSB first, [even parity ^ par_flip], stop.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        fall_cyc = cyc;
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(b[i], C);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ par_flip, C);
`endif
        hold(stop, C);
    endtask

    task automatic test_reset;
        @(negedge clk);
        nchk++; if (ready !== 1'b1)        begin nerr++; $display("FAIL reset_ready got %0b want 1", ready); end
        nchk++; if (data_byte !== 8'h00)   begin nerr++; $display("FAIL reset_data got %h want 00", data_byte); end
        nchk++; if (data_valid !== 1'b0)   begin nerr++; $display("FAIL reset_valid got %0b want 0", data_valid); end
        nchk++; if (frame_error !== 1'b0)  begin nerr++; $display("FAIL reset_ferr got %0b want 0", frame_error); end
        rst = 1'b0;
        hold(1'b1, 20);
    endtask

    task automatic test_single_frame;
        int v0, f0, lat;
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h70, 1'b1, 1'b0);
        hold(1'b1, 4);
        lat = vcyc - fall_cyc;
        nchk++; if (vcnt - v0 !== 1)  begin nerr++; $display("FAIL single_pulses got %0d want 1", vcnt - v0); end
        nchk++; if (vlast !== 8'h70)  begin nerr++; $display("FAIL single_data got %h want 70", vlast); end
        // 2 sync + C/2 start + 9*C bits + 1 register = 155 for C=16
        nchk++; if (lat < 154 || lat > 156) begin nerr++; $display("FAIL single_latency got %0d want 155+-1", lat); end
        nchk++; if (fcnt !== f0)      begin nerr++; $display("FAIL single_ferr got %0d want 0", fcnt - f0); end
        nchk++; if (data_byte !== 8'h70) begin nerr++; $display("FAIL single_hold got %h want 70", data_byte); end
    endtask

    task automatic test_back_to_back;
        int v0, f0;
        logic [7:0] a, b;
        v0 = vcnt; f0 = fcnt;
        vals.delete();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        hold(1'b1, 4);
        nchk++; if (vcnt - v0 !== 2) begin nerr++; $display("FAIL b2b_pulses got %0d want 2", vcnt - v0); end
        a = (vals.size() > 0) ? vals[0] : 8'hxx;
        b = (vals.size() > 1) ? vals[1] : 8'hxx;
        nchk++; if (a !== 8'hA5) begin nerr++; $display("FAIL b2b_first got %h want a5", a); end
        nchk++; if (b !== 8'h3C) begin nerr++; $display("FAIL b2b_second got %h want 3c", b); end
        nchk++; if (fcnt !== f0) begin nerr++; $display("FAIL b2b_ferr got %0d want 0", fcnt - f0); end
    endtask

    task automatic test_glitch;
        int v0, f0, n;
        v0 = vcnt; f0 = fcnt;
        hold(1'b0, 4);
        nchk++; if (ready !== 1'b0) begin nerr++; $display("FAIL glitch_detect ready got %0b want 0", ready); end
        rx = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        nchk++; if (ready !== 1'b1) begin nerr++; $display("FAIL glitch_ready got %0b want 1 within 12", ready); end
        hold(1'b1, 2 * C);
        nchk++; if (vcnt !== v0 || fcnt !== f0) begin
            nerr++; $display("FAIL glitch_pulses got valid %0d ferr %0d want 0 0", vcnt - v0, fcnt - f0);
        end
    endtask

    task automatic test_frame_error;
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h55, 1'b0, 1'b0);
        hold(1'b0, 100);
        nchk++; if (fcnt - f0 !== 1)     begin nerr++; $display("FAIL ferr_pulses got %0d want 1", fcnt - f0); end
        nchk++; if (vcnt !== v0)         begin nerr++; $display("FAIL ferr_valid got %0d want 0", vcnt - v0); end
        nchk++; if (data_byte !== 8'h3C) begin nerr++; $display("FAIL ferr_data got %h want 3c", data_byte); end
        nchk++; if (ready !== 1'b0)      begin nerr++; $display("FAIL ferr_ready_low got %0b want 0", ready); end
        hold(1'b1, 6);
        nchk++; if (ready !== 1'b1)      begin nerr++; $display("FAIL ferr_ready_high got %0b want 1", ready); end
        nchk++; if (fcnt - f0 !== 1)     begin nerr++; $display("FAIL ferr_once got %0d want 1", fcnt - f0); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, f0;
        logic [7:0] ff;
        ff = 8'hFF;
        v0 = vcnt; f0 = fcnt;
        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(ff[i], C);
        hold(1'b1, C / 2);
        rst = 1'b1;
        #1;
        nchk++; if (ready !== 1'b1)      begin nerr++; $display("FAIL rstmid_ready got %0b want 1", ready); end
        nchk++; if (data_byte !== 8'h00) begin nerr++; $display("FAIL rstmid_data got %h want 00", data_byte); end
        hold(1'b1, 2);
        rst = 1'b0;
        hold(1'b1, 20);
        nchk++; if (vcnt !== v0 || fcnt !== f0) begin
            nerr++; $display("FAIL rstmid_pulses got valid %0d ferr %0d want 0 0", vcnt - v0, fcnt - f0);
        end
        send_frame(8'h81, 1'b1, 1'b0);
        hold(1'b1, 4);
        nchk++; if (vcnt - v0 !== 1 || vlast !== 8'h81) begin
            nerr++; $display("FAIL rstmid_next got %0d pulses data %h want 1 81", vcnt - v0, vlast);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, p0;
        v0 = vcnt; p0 = pcnt;
        send_frame(8'h07, 1'b1, 1'b0);
        hold(1'b1, 4);
        nchk++; if (pcnt !== p0)     begin nerr++; $display("FAIL parity_good got %0d pulses want 0", pcnt - p0); end
        nchk++; if (vcnt - v0 !== 1) begin nerr++; $display("FAIL parity_good_valid got %0d want 1", vcnt - v0); end
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 4);
        nchk++; if (pcnt - p0 !== 1) begin nerr++; $display("FAIL parity_bad got %0d pulses want 1", pcnt - p0); end
        nchk++; if (vcnt - v0 !== 2 || vlast !== 8'h07) begin
            nerr++; $display("FAIL parity_bad_valid got %0d data %h want 2 07", vcnt - v0, vlast);
        end
    endtask
`endif

    task automatic test_exclusive;
        nchk++; if (both_seen !== 1'b0) begin nerr++; $display("FAIL exclusive got both high want never"); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_exclusive;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
